// File: rtl/glitch_seq_if.sv
// ---------------------------------------------------------------------------
// glitch_seq_if -- bundle of control/status signals for the glitch sequencer.
//   master : drives the request fields (en, abort, trig, delay, width, gap,
//            count, mode) and observes status.
//   slave  : the sequencer; receives requests, drives ready, busy,
//            glitch_en, mode_out, pulse_idx, done.
// ---------------------------------------------------------------------------
interface glitch_seq_if #(
   parameter int DELAY_W = 16,
   parameter int WIDTH_W = 8,
   parameter int CNT_W   = 8
);
   logic               en;
   logic               abort;
   logic               trig;
   logic [DELAY_W-1:0] delay;
   logic [WIDTH_W-1:0] width;
   logic [DELAY_W-1:0] gap;
   logic [CNT_W-1:0]   count;
   logic [7:0]         mode;
   logic               ready;
   logic               busy;
   logic               glitch_en;
   logic [7:0]         mode_out;
   logic [CNT_W-1:0]   pulse_idx;
   logic               done;

   modport master (
      output en, abort, trig, delay, width, gap, count, mode,
      input  ready, busy, glitch_en, mode_out, pulse_idx, done
   );

   modport slave (
      input  en, abort, trig, delay, width, gap, count, mode,
      output ready, busy, glitch_en, mode_out, pulse_idx, done
   );
endinterface

// File: rtl/glitch_seq.sv
// ---------------------------------------------------------------------------
// glitch_seq -- programmable glitch pulse sequencer.
// A start (en in IDLE) latches delay/width/gap/count/mode, waits `delay`
// cycles, then emits `count` pulses of `width` high cycles separated by
// `gap` low cycles on a registered glitch_en. done strobes for one cycle on
// normal completion; abort returns to IDLE without done.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : glitch_seq_if.slave (en, abort, trig, delay, width, gap, count,
//          mode in; ready, busy, glitch_en, mode_out, pulse_idx, done out)
//
// Optional feature: define GLITCH_SEQ_TRIG_EN to make a start wait in ARM
// for a rising edge of the registered trig input; the edge cycle then
// replaces the start cycle for delay timing. Without it, trig is ignored.
// ---------------------------------------------------------------------------
module glitch_seq #(
   parameter int DELAY_W = 16,
   parameter int WIDTH_W = 8,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   glitch_seq_if.slave bus
);

   typedef enum logic [2:0] {IDLE, ARM, DELAY, WIDTH, GAP} state_t;

   state_t             state_q;
   logic [DELAY_W-1:0] delay_q, gap_q, dcnt_q;
   logic [WIDTH_W-1:0] width_q, wcnt_q;
   logic [CNT_W-1:0]   count_q, pidx_q;
   logic [7:0]         mode_q;
   logic               glitch_q, done_q;

`ifdef GLITCH_SEQ_TRIG_EN
   logic trig_q, trig_p_q;
   wire  trig_edge = trig_q & ~trig_p_q;
`endif

   // gap and count are stored normalised (0 -> 1) so every compare below
   // is a plain "latched value minus 1" with no special cases.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         delay_q  <= '0;
         gap_q    <= '0;
         width_q  <= '0;
         count_q  <= '0;
         mode_q   <= '0;
         dcnt_q   <= '0;
         wcnt_q   <= '0;
         pidx_q   <= '0;
         glitch_q <= 1'b0;
         done_q   <= 1'b0;
`ifdef GLITCH_SEQ_TRIG_EN
         trig_q   <= 1'b0;
         trig_p_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef GLITCH_SEQ_TRIG_EN
         trig_q   <= bus.trig;
         trig_p_q <= trig_q;
`endif
         if (state_q != IDLE && bus.abort) begin
            state_q  <= IDLE;
            glitch_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  // abort in the same cycle suppresses a start
                  if (bus.en && !bus.abort) begin
                     delay_q <= bus.delay;
                     width_q <= bus.width;
                     gap_q   <= (bus.gap == '0) ? DELAY_W'(1) : bus.gap;
                     count_q <= (bus.count == '0) ? CNT_W'(1) : bus.count;
                     mode_q  <= bus.mode;
                     dcnt_q  <= '0;
                     wcnt_q  <= '0;
                     pidx_q  <= '0;
                     if (bus.width == '0) begin
                        done_q <= 1'b1;
`ifdef GLITCH_SEQ_TRIG_EN
                     end else begin
                        state_q <= ARM;
                     end
`else
                     end else if (bus.delay == '0) begin
                        state_q  <= WIDTH;
                        glitch_q <= 1'b1;
                     end else begin
                        state_q <= DELAY;
                     end
`endif
                  end
               end
               ARM: begin
`ifdef GLITCH_SEQ_TRIG_EN
                  if (trig_edge) begin
                     if (delay_q == '0) begin
                        state_q  <= WIDTH;
                        glitch_q <= 1'b1;
                     end else begin
                        state_q <= DELAY;
                     end
                  end
`else
                  state_q <= IDLE;
`endif
               end
               DELAY: begin
                  if (dcnt_q == delay_q - DELAY_W'(1)) begin
                     state_q  <= WIDTH;
                     glitch_q <= 1'b1;
                  end else begin
                     dcnt_q <= dcnt_q + DELAY_W'(1);
                  end
               end
               WIDTH: begin
                  if (wcnt_q == width_q - WIDTH_W'(1)) begin
                     glitch_q <= 1'b0;
                     if (pidx_q == count_q - CNT_W'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= GAP;
                        dcnt_q  <= '0;
                     end
                  end else begin
                     wcnt_q <= wcnt_q + WIDTH_W'(1);
                  end
               end
               GAP: begin
                  if (dcnt_q == gap_q - DELAY_W'(1)) begin
                     state_q  <= WIDTH;
                     glitch_q <= 1'b1;
                     wcnt_q   <= '0;
                     pidx_q   <= pidx_q + CNT_W'(1);
                  end else begin
                     dcnt_q <= dcnt_q + DELAY_W'(1);
                  end
               end
               default: begin
                  state_q  <= IDLE;
                  glitch_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.ready     = (state_q == IDLE) && !bus.en;
   assign bus.busy      = (state_q != IDLE);
   assign bus.glitch_en = glitch_q;
   assign bus.mode_out  = mode_q;
   assign bus.pulse_idx = pidx_q;
   assign bus.done      = done_q;

endmodule

// File: doc/glitch_seq.md
GLITCH_SEQ -- requirements
Module: glitch_seq

Interface
REQ-001 Parameter DELAY_W, default 16: width of the delay and gap fields.
REQ-002 Parameter WIDTH_W, default 8: width of the pulse-width field.
REQ-003 Parameter CNT_W, default 8: width of the pulse-count field.
REQ-004 clk  in  1  clock; all logic is on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 en  in  1  start request, sampled only in IDLE.
REQ-007 abort  in  1  terminates any sequence immediately.
REQ-008 trig  in  1  external trigger; used only under GLITCH_SEQ_TRIG_EN.
REQ-009 delay  in  DELAY_W  cycles from start (or trigger) to the first pulse.
REQ-010 width  in  WIDTH_W  high cycles per pulse.
REQ-011 gap  in  DELAY_W  low cycles between consecutive pulses.
REQ-012 count  in  CNT_W  number of pulses.
REQ-013 mode  in  8  glitch mode, passed through to the glitch core.
REQ-014 ready  out  1  high when state is IDLE and en is low.
REQ-015 busy  out  1  high when state is not IDLE.
REQ-016 glitch_en  out  1  registered glitch enable.
REQ-017 mode_out  out  8  mode latched at start.
REQ-018 pulse_idx  out  CNT_W  zero-based index of the current or last pulse.
REQ-019 done  out  1  one-cycle strobe on normal completion.

Function
REQ-020 The block SHALL implement states IDLE, ARM, DELAY, WIDTH and GAP.
REQ-021 In IDLE with en=1 at cycle T, it SHALL latch delay, width, gap, count and mode, clear all counters, and ignore later input changes until the next return to IDLE.
REQ-022 Start with width=0 SHALL stay in IDLE, keep glitch_en low, and assert done at T+1.
REQ-023 count=0 SHALL behave as count=1.
REQ-024 With delay=0, glitch_en SHALL be high from T+1; with delay=D>0, DELAY SHALL last D cycles and glitch_en SHALL rise at T+1+D.
REQ-025 Each pulse SHALL hold glitch_en high for exactly the latched width cycles.
REQ-026 After a pulse that is not the last, GAP SHALL hold glitch_en low for the latched gap cycles; gap=0 SHALL behave as gap=1.
REQ-027 pulse_idx SHALL increment at each GAP-to-WIDTH transition and reset to 0 at start.
REQ-028 After the last pulse, the block SHALL return to IDLE with glitch_en low and done high for exactly one cycle.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE and glitch_en=0 on the next cycle, with no done.
REQ-030 abort SHALL take priority over en in the same cycle.
REQ-031 All counters SHALL use unsigned compare against the latched value minus 1 and SHALL NOT wrap within a sequence.
REQ-032 Maximum-value fields, e.g. width = 2^WIDTH_W-1, SHALL produce exactly that many cycles.

Reset
REQ-033 rst SHALL force IDLE and clear glitch_en, done, mode_out, pulse_idx and all latched fields and counters.
REQ-034 rst SHALL take priority over abort and en.
REQ-035 rst mid-pulse SHALL drop glitch_en on the next cycle.
REQ-036 After reset, ready SHALL equal !en and busy SHALL be 0.

Configuration
REQ-037 With GLITCH_SEQ_TRIG_EN defined, a start SHALL enter ARM and wait for a rising edge of trig.
REQ-038 With GLITCH_SEQ_TRIG_EN defined, trig SHALL be registered, and the edge cycle SHALL take the place of T for delay timing.
REQ-039 With GLITCH_SEQ_TRIG_EN defined, abort SHALL exit ARM to IDLE.
REQ-040 Without GLITCH_SEQ_TRIG_EN, ARM SHALL be unreachable, trig SHALL be ignored, and timing SHALL follow REQ-024.

Verification
REQ-041 delay=3, width=2, count=1, en at T -> glitch_en high for T+4..T+5; done at T+6; ready at T+6 if en is low.
REQ-042 delay=0, width=1, gap=2, count=3 -> glitch_en pattern 1,0,0,1,0,0,1 from T+1; pulse_idx 0,1,2; one done.
REQ-043 width=0, count=5 -> glitch_en never high; done at T+1; busy stays 0.
REQ-044 width=4, count=2, abort on the second cycle of the first pulse -> glitch_en low on the next cycle; IDLE; no done.
REQ-045 rst asserted during GAP -> all outputs reach reset values the next cycle; a fresh en then starts normally.
REQ-046 With GLITCH_SEQ_TRIG_EN: delay=2, width=1, trig rises 10 cycles after en -> glitch_en high exactly 3 cycles after the registered edge; without the macro, trig toggling has no effect.
